// File: rtl/sdspi_if.sv
// sdspi_if -- CPU register-bus bundle for the SD-card SPI master.
//   io_addr   : register select (CPU addr[4:1])
//   io_write  : one-cycle write strobe
//   io_read   : one-cycle read strobe (read side effects only)
//   io_wdata  : write data
//   io_rdata  : read data, combinational from io_addr
//   interrupt : level interrupt (ie & rxv)
interface sdspi_if;
  logic [3:0] io_addr;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       interrupt;

  modport master (
    output io_addr, io_write, io_read, io_wdata,
    input  io_rdata, interrupt
  );

  modport slave (
    input  io_addr, io_write, io_read, io_wdata,
    output io_rdata, interrupt
  );
endinterface

// File: rtl/sdspi.sv
// sdspi -- byte-wide SPI master (mode 0, MSB first) for an SD card.
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : register bus (sdspi_if.slave)
//             0 DATA   wr: start transfer, rd: rx_data (read clears rxv)
//             1 STATUS {4'b0, ie, ovr, rxv, busy}; wr bit2 clears ovr, bit3 loads ie
//             2 CTRL   {2'b0, cs, 1'b0, div[3:0]}
//             3..15    read as zero, writes ignored
//   sclk  : SPI clock, idles low, half-period div_shadow+1 clk cycles
//   mosi  : serial out, changes on sclk falling edges
//   miso  : serial in, sampled on sclk rising edges
//   cs_n  : card select, ~cs
module sdspi #(
  parameter logic [3:0] DIV_RST = 4'd3
) (
  input  logic    clk,
  input  logic    reset,
  sdspi_if.slave  bus,
  output logic    sclk,
  output logic    mosi,
  input  logic    miso,
  output logic    cs_n
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     r_state;
  logic [7:0] r_sh;
  logic [7:0] r_rx;
  logic [3:0] r_div;
  logic [3:0] r_div_sh;
  logic [4:0] r_cnt;
  logic [2:0] r_bit;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_rxv;
  logic       r_ovr;
  logic       r_ie;
  logic       r_cs;

  logic w_wr_data;
  logic w_wr_stat;
  logic w_wr_ctrl;
  logic w_rd_data;
  logic w_tick;
  logic w_done;

  assign w_wr_data = bus.io_write && (bus.io_addr == 4'd0);
  assign w_wr_stat = bus.io_write && (bus.io_addr == 4'd1);
  assign w_wr_ctrl = bus.io_write && (bus.io_addr == 4'd2);
  assign w_rd_data = bus.io_read  && (bus.io_addr == 4'd0);
  assign w_tick    = (r_cnt == 5'd0);
  assign w_done    = (r_state == SHIFT) && w_tick && r_sclk && (r_bit == 3'd7);

  assign sclk          = r_sclk;
  assign mosi          = r_mosi;
  assign cs_n          = ~r_cs;
  assign bus.interrupt = r_ie & r_rxv;

  always_comb begin
    bus.io_rdata = '0;
    case (bus.io_addr)
      4'd0:    bus.io_rdata = r_rx;
      4'd1:    bus.io_rdata = {4'b0, r_ie, r_ovr, r_rxv, r_state == SHIFT};
      4'd2:    bus.io_rdata = {2'b0, r_cs, 1'b0, r_div};
      default: bus.io_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_sh     <= '0;
      r_rx     <= '0;
      r_div    <= DIV_RST;
      r_div_sh <= DIV_RST;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_rxv    <= 1'b0;
      r_ovr    <= 1'b0;
      r_ie     <= 1'b0;
      r_cs     <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_cs  <= bus.io_wdata[5];
        r_div <= bus.io_wdata[3:0];
      end
      if (w_wr_stat) r_ie <= bus.io_wdata[3];

      // Overrun set takes priority over a software clear in the same cycle.
      if (w_wr_stat && bus.io_wdata[2]) r_ovr <= 1'b0;
      if ((w_wr_data && r_state == SHIFT) || (w_done && r_rxv)) r_ovr <= 1'b1;

      // Completion below is assigned later, so its rxv set wins over this clear.
      if (w_rd_data) r_rxv <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_wr_data) begin
            r_state  <= SHIFT;
            r_sh     <= bus.io_wdata;
            r_mosi   <= bus.io_wdata[7];
            r_div_sh <= r_div;
            // One extra cycle before the first half-period starts counting.
            r_cnt    <= {1'b0, r_div} + 5'd1;
            r_bit    <= '0;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            r_cnt  <= {1'b0, r_div_sh};
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              // Rising edge: the shifter doubles as tx and rx register.
              r_sh <= {r_sh[6:0], miso};
            end else if (r_bit == 3'd7) begin
              r_state <= IDLE;
              r_rx    <= r_sh;
              r_rxv   <= 1'b1;
            end else begin
              r_bit  <= r_bit + 3'd1;
              r_mosi <= r_sh[7];
            end
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdspi.sv
module tb_sdspi;
  localparam logic [3:0] DIV_RST = 4'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sclk, mosi, cs_n, miso;
  logic miso_drv = 1'b0;
  logic loop = 1'b0;

  assign miso = loop ? mosi : miso_drv;

  sdspi_if bus ();

  sdspi #(.DIV_RST(DIV_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the programmer-visible state.
  logic       m_ie, m_rxv, m_ovr, m_cs;
  logic [3:0] m_div;
  logic [7:0] m_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ie = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0; m_cs = 1'b0;
    m_div = DIV_RST; m_rx = 8'h00;
  endtask

  // Idle-state register and pin check; called away from clock edges.
  task automatic check_regs(input string tag);
    bus.io_addr = 4'd0; #1;
    chk({tag, "_data"}, bus.io_rdata, m_rx);
    bus.io_addr = 4'd1; #1;
    chk({tag, "_stat"}, bus.io_rdata, {4'b0, m_ie, m_ovr, m_rxv, 1'b0});
    bus.io_addr = 4'd2; #1;
    chk({tag, "_ctrl"}, bus.io_rdata, {2'b0, m_cs, 1'b0, m_div});
    chk({tag, "_pins"}, {sclk, cs_n, bus.interrupt}, {1'b0, ~m_cs, m_ie & m_rxv});
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus.io_addr = a; bus.io_wdata = d; bus.io_write = 1'b1;
    @(posedge clk); #1;
    bus.io_write = 1'b0;
  endtask

  task automatic read_data(input logic [7:0] exp);
    bus.io_addr = 4'd0; bus.io_read = 1'b1; #1;
    chk("rd_data", bus.io_rdata, exp);
    @(posedge clk); #1;
    bus.io_read = 1'b0;
    m_rxv = 1'b0;
    check_regs("after_rd");
  endtask

  // mode: 0 plain, 1 second DATA write while busy, 2 CTRL div=7 mid-byte,
  //       3 reset asserted at cycle 7.
  task automatic do_xfer(input logic [3:0] d, input logic [7:0] tx, input logic [7:0] rxb,
                         input logic lp, input int mode);
    int n, half, idx, rises, hp;
    logic [7:0] exp;
    bus_write(4'd2, {2'b0, m_cs, 1'b0, d});
    m_div = d;
    loop = lp;
    miso_drv = rxb[7];
    exp = lp ? tx : rxb;
    hp = int'(d) + 1;
    n = 16 * hp;
    bus_write(4'd0, tx);
    for (int c = 1; c <= n + 2; c++) begin
      if (mode == 1 && c == 1) begin
        bus.io_addr = 4'd0; bus.io_wdata = ~tx; bus.io_write = 1'b1;
      end
      if (mode == 2 && c == 3) begin
        bus.io_addr = 4'd2; bus.io_wdata = {2'b0, m_cs, 1'b0, 4'd7}; bus.io_write = 1'b1;
      end
      @(posedge clk); #1;
      bus.io_write = 1'b0;
      if (mode == 3 && c == 7) begin
        reset = 1'b0;
        bus.io_addr = 4'd1; #1;
        chk("abort_pins", {sclk, cs_n, mosi, bus.interrupt}, 4'b0110);
        chk("abort_stat", bus.io_rdata, 8'h00);
        model_reset();
        #2 reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          chk("post_abort", {sclk, bus.io_rdata}, 9'h000);
        end
        return;
      end
      if (mode == 2 && c == 3) begin
        m_div = 4'd7;
        bus.io_addr = 4'd2; #1;
        chk("ctrl_mid", bus.io_rdata, {2'b0, m_cs, 1'b0, 4'd7});
      end
      half = (c - 1) / hp;
      idx = half / 2;
      if (idx > 7) idx = 7;
      bus.io_addr = 4'd1; #1;
      chk($sformatf("shift_c%0d", c), {sclk, mosi, bus.io_rdata[0]},
          {(half < 16) && (half % 2 == 1), tx[7 - idx], c <= n});
      rises = (half + 1) / 2;
      if (rises > 7) rises = 7;
      miso_drv = rxb[7 - rises];
    end
    if (m_rxv || mode == 1) m_ovr = 1'b1;
    m_rxv = 1'b1;
    m_rx = exp;
    check_regs("xfer_end");
  endtask

  initial begin
    logic [3:0] rd;
    logic [7:0] rtx, rrx;
    bus.io_addr = '0; bus.io_write = 1'b0; bus.io_read = 1'b0; bus.io_wdata = '0;
    model_reset();
    #3;
    check_regs("reset");
    chk("reset_mosi", mosi, 1'b1);
    #4 reset = 1'b1;
    @(posedge clk); #1;

    for (int a = 3; a < 16; a++) begin
      bus.io_addr = 4'(a); #1;
      chk("unmapped_rd", bus.io_rdata, 8'h00);
    end
    @(posedge clk); #1;
    bus_write(4'd3, 8'hFF);
    bus_write(4'd15, 8'hFF);
    check_regs("unmapped_wr");

    // Bit4 is reserved and reads back zero; bit5 is cs.
    bus_write(4'd2, 8'h30);
    m_cs = 1'b1; m_div = 4'd0;
    check_regs("cs_on");

    do_xfer(4'd0, 8'hA5, 8'h00, 1'b1, 0);
    read_data(8'hA5);

    bus_write(4'd1, 8'h08);
    m_ie = 1'b1;
    do_xfer(4'd3, 8'h3C, 8'hFF, 1'b0, 0);
    read_data(8'hFF);

    do_xfer(4'd1, 8'h5A, 8'hC3, 1'b0, 1);
    bus_write(4'd1, 8'h04);
    m_ovr = 1'b0; m_ie = 1'b0;
    check_regs("ovr_clr");

    do_xfer(4'd0, 8'h11, 8'h22, 1'b0, 0);
    do_xfer(4'd2, 8'h33, 8'h44, 1'b0, 0);
    read_data(8'h44);
    bus_write(4'd1, 8'h04);
    m_ovr = 1'b0;

    do_xfer(4'd1, 8'h96, 8'h69, 1'b0, 2);
    do_xfer(4'd7, 8'hC5, 8'h3A, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      rd  = 4'($urandom_range(0, 3));
      rtx = 8'($urandom);
      rrx = 8'($urandom);
      do_xfer(rd, rtx, rrx, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) read_data(m_rx);
    end

    do_xfer(4'd1, 8'hAA, 8'h55, 1'b0, 3);
    check_regs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
